// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the OTTER pipeline stall/flush sequencer.
// Per-stage controls are bundled so one assignment drives every pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MD_BUSY  = 2'd2,
        REDIRECT = 2'd3
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic fe_de_en;
        logic de_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic fe_de_flush;
        logic de_ex_flush;
        logic ex_mem_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t FREEZE_ALL  = stage_ctrl_t'(8'b0000_0000);
    localparam stage_ctrl_t BOOT_CTRL   = stage_ctrl_t'(8'b0000_0111);
    localparam stage_ctrl_t RUN_ALL     = stage_ctrl_t'(8'b1111_1000);
    // Taken branch: PC loads the target, the two wrong-path stages become bubbles.
    localparam stage_ctrl_t BRANCH_CTRL = stage_ctrl_t'(8'b1111_1110);

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-request / stage-control bundle between the pipeline datapath and pipe_ctrl.
// master = datapath (raises requests), slave = sequencer (drives enables/flushes).
interface pipe_ctrl_if;
    logic LOAD_USE;
    logic BR_TAKEN;
    logic IMEM_WAIT;
    logic DMEM_WAIT;
    logic MD_START;
    logic MD_DONE;
    logic PC_EN;
    logic FE_DE_EN;
    logic DE_EX_EN;
    logic EX_MEM_EN;
    logic MEM_WB_EN;
    logic FE_DE_FLUSH;
    logic DE_EX_FLUSH;
    logic EX_MEM_FLUSH;
    logic BUSY;

    modport master (
        output LOAD_USE, BR_TAKEN, IMEM_WAIT, DMEM_WAIT, MD_START, MD_DONE,
        input  PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN,
               FE_DE_FLUSH, DE_EX_FLUSH, EX_MEM_FLUSH, BUSY
    );

    modport slave (
        input  LOAD_USE, BR_TAKEN, IMEM_WAIT, DMEM_WAIT, MD_START, MD_DONE,
        output PC_EN, FE_DE_EN, DE_EX_EN, EX_MEM_EN, MEM_WB_EN,
               FE_DE_FLUSH, DE_EX_FLUSH, EX_MEM_FLUSH, BUSY
    );
endinterface

// File: rtl/perf_sat_cnt.sv
// Saturating event counter: +1 per cycle with i_inc, sticks at all-ones, no wrap.
// Count visible the cycle after the event; no backpressure.
module perf_sat_cnt #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// Fixed-priority stall/flush sequencer for the 5-stage pipeline; outputs are combinational (0-cycle).
// DMEM_WAIT freezes everything incl. state; optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    pipe_ctrl_if.slave        bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] STALL_CYC,
    output logic [PERF_W-1:0] FLUSH_CYC,
    output logic [PERF_W-1:0] MD_CYC
`endif
);
    pctrl_state_t r_state;
    logic [2:0]   r_cnt;
    pctrl_state_t w_nxt_state;
    logic [2:0]   w_nxt_cnt;
    stage_ctrl_t  w_ctrl;

    always_comb begin
        w_ctrl      = RUN_ALL;
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        unique case (r_state)
            BOOT: begin
                w_ctrl      = BOOT_CTRL;
                w_nxt_state = RUN;
            end
            RUN: begin
                if (bus.DMEM_WAIT) begin
                    w_ctrl = FREEZE_ALL;
                end else if (bus.BR_TAKEN) begin
                    w_ctrl = BRANCH_CTRL;
                    if (FLUSH_CYCLES > 0) begin
                        w_nxt_state = REDIRECT;
                        w_nxt_cnt   = 3'(FLUSH_CYCLES);
                    end
                end else if (bus.MD_START) begin
                    w_nxt_state = MD_BUSY;
                end else if (bus.LOAD_USE) begin
                    w_ctrl.pc_en       = 1'b0;
                    w_ctrl.fe_de_en    = 1'b0;
                    w_ctrl.de_ex_flush = 1'b1;
                end else if (bus.IMEM_WAIT) begin
                    w_ctrl.pc_en       = 1'b0;
                    w_ctrl.fe_de_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                // EX holds the mul/div, so a branch cannot resolve here.
                if (bus.DMEM_WAIT) begin
                    w_ctrl = FREEZE_ALL;
                end else if (bus.MD_DONE) begin
                    w_nxt_state = RUN;
                end else begin
                    w_ctrl.pc_en        = 1'b0;
                    w_ctrl.fe_de_en     = 1'b0;
                    w_ctrl.de_ex_en     = 1'b0;
                    w_ctrl.ex_mem_flush = 1'b1;
                end
            end
            REDIRECT: begin
                if (bus.DMEM_WAIT) begin
                    w_ctrl = FREEZE_ALL;
                end else if (bus.BR_TAKEN) begin
                    w_ctrl    = BRANCH_CTRL;
                    w_nxt_cnt = 3'(FLUSH_CYCLES);
                    if (FLUSH_CYCLES == 0) begin
                        w_nxt_state = RUN;
                    end
                end else begin
                    w_ctrl.fe_de_flush = 1'b1;
                    w_ctrl.pc_en       = !bus.IMEM_WAIT;
                    w_nxt_cnt          = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_nxt_state = RUN;
                    end
                end
            end
            default: begin
                w_ctrl      = BOOT_CTRL;
                w_nxt_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= BOOT;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign bus.PC_EN        = w_ctrl.pc_en;
    assign bus.FE_DE_EN     = w_ctrl.fe_de_en;
    assign bus.DE_EX_EN     = w_ctrl.de_ex_en;
    assign bus.EX_MEM_EN    = w_ctrl.ex_mem_en;
    assign bus.MEM_WB_EN    = w_ctrl.mem_wb_en;
    assign bus.FE_DE_FLUSH  = w_ctrl.fe_de_flush;
    assign bus.DE_EX_FLUSH  = w_ctrl.de_ex_flush;
    assign bus.EX_MEM_FLUSH = w_ctrl.ex_mem_flush;
    assign bus.BUSY         = (r_state != RUN);

`ifdef PIPE_CTRL_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_md_inc;

    assign w_stall_inc = ((r_state == RUN) || (r_state == MD_BUSY)) && !w_ctrl.pc_en;
    assign w_flush_inc = (r_state != BOOT) && w_ctrl.fe_de_flush;
    assign w_md_inc    = (r_state == MD_BUSY);

    perf_sat_cnt #(.W(PERF_W)) u_stall_cnt (
        .i_clk(CLK), .i_rst_n(RST_N), .i_inc(w_stall_inc), .o_cnt(STALL_CYC)
    );
    perf_sat_cnt #(.W(PERF_W)) u_flush_cnt (
        .i_clk(CLK), .i_rst_n(RST_N), .i_inc(w_flush_inc), .o_cnt(FLUSH_CYC)
    );
    perf_sat_cnt #(.W(PERF_W)) u_md_cnt (
        .i_clk(CLK), .i_rst_n(RST_N), .i_inc(w_md_inc), .o_cnt(MD_CYC)
    );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a behavioural model of the pipeline sequencing rules.
// Builds with or without PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
    localparam int FC = 2;
    localparam int PW = 4;
    localparam int SAT = (1 << PW) - 1;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic lu, br, iw, dw, ms, md;
    pipe_ctrl_if bus_if ();
    assign bus_if.LOAD_USE  = lu;
    assign bus_if.BR_TAKEN  = br;
    assign bus_if.IMEM_WAIT = iw;
    assign bus_if.DMEM_WAIT = dw;
    assign bus_if.MD_START  = ms;
    assign bus_if.MD_DONE   = md;

`ifdef PIPE_CTRL_PERF_EN
    logic [PW-1:0] stall_cyc, flush_cyc, md_cyc;
`endif

    pipe_ctrl #(.FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus_if)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .STALL_CYC(stall_cyc),
        .FLUSH_CYC(flush_cyc),
        .MD_CYC(md_cyc)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model: pending boot cycle, mul/div in flight, remaining redirect cycles, perf counts.
    bit m_boot;
    bit m_md;
    int m_redir;
    int m_stall, m_flush, m_mdc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Order: pc, fe_de_en, de_ex_en, ex_mem_en, mem_wb_en, fe_de_fl, de_ex_fl, ex_mem_fl, busy
    function automatic logic [8:0] expect_out();
        logic pc, fe, de, ex, wb, fef, def, exf;
        pc = 1; fe = 1; de = 1; ex = 1; wb = 1; fef = 0; def = 0; exf = 0;
        if (m_boot) begin
            {pc, fe, de, ex, wb} = '0;
            {fef, def, exf} = 3'b111;
        end else if (dw) begin
            {pc, fe, de, ex, wb} = '0;
        end else if (m_md) begin
            if (!md) begin
                pc = 0; fe = 0; de = 0; exf = 1;
            end
        end else if (br) begin
            fef = 1; def = 1;
        end else if (m_redir > 0) begin
            fef = 1; pc = !iw;
        end else if (ms) begin
            pc = 1;
        end else if (lu) begin
            pc = 0; fe = 0; def = 1;
        end else if (iw) begin
            pc = 0; fef = 1;
        end
        return {pc, fe, de, ex, wb, fef, def, exf, (m_boot || m_md || m_redir > 0)};
    endfunction

    function automatic logic [8:0] got_out();
        return {bus_if.PC_EN, bus_if.FE_DE_EN, bus_if.DE_EX_EN, bus_if.EX_MEM_EN,
                bus_if.MEM_WB_EN, bus_if.FE_DE_FLUSH, bus_if.DE_EX_FLUSH,
                bus_if.EX_MEM_FLUSH, bus_if.BUSY};
    endfunction

    task automatic check_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
        check({tag, "_stall"}, 32'(stall_cyc), 32'(m_stall));
        check({tag, "_flush"}, 32'(flush_cyc), 32'(m_flush));
        check({tag, "_md"},    32'(md_cyc),    32'(m_mdc));
`endif
    endtask

    task automatic model_reset();
        m_boot = 1; m_md = 0; m_redir = 0;
        m_stall = 0; m_flush = 0; m_mdc = 0;
    endtask

    task automatic model_step(input logic [8:0] e);
        bit in_run_or_md;
        in_run_or_md = !m_boot && (m_redir == 0);
        if (in_run_or_md && !e[8] && m_stall < SAT) m_stall++;
        if (!m_boot && e[3] && m_flush < SAT) m_flush++;
        if (m_md && m_mdc < SAT) m_mdc++;
        if (m_boot) m_boot = 0;
        else if (!dw) begin
            if (m_md) begin
                if (md) m_md = 0;
            end else if (br) m_redir = FC;
            else if (m_redir > 0) m_redir--;
            else if (ms) m_md = 1;
        end
    endtask

    // Called just after a falling edge; returns on a later falling edge with reset released.
    task automatic pulse_reset(input string tag);
        RST_N = 1'b0;
        #1;
        check(tag, 32'(got_out()), 32'(9'b00000_111_1));
        model_reset();
        check_perf(tag);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        logic [8:0] e;
        {lu, br, iw, dw, ms, md} = '0;
        RST_N = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        pulse_reset("reset");
        for (int i = 0; i < 3000; i++) begin
            if (i > 20 && $urandom_range(99) == 0) pulse_reset("async_reset");
            dw = ($urandom_range(99) < 12);
            br = ($urandom_range(99) < 12);
            ms = ($urandom_range(99) < 10);
            lu = ($urandom_range(99) < 25);
            iw = ($urandom_range(99) < 25);
            md = ($urandom_range(99) < 25);
            #1;
            e = expect_out();
            check("ctrl", 32'(got_out()), 32'(e));
            check_perf("perf");
            model_step(e);
            @(negedge CLK);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
